multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

Parametrised successor to the current multi-cycle control unit. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with per-instruction stage skipping, ready handshakes to instruction and data memory, and a wait-timeout watchdog. It decodes the RV32I major opcode into datapath controls and counts retired instructions. It sits between the memories and the datapath stage registers of the multi-cycle CPU core.

## Interface
- OPC_W, 7, opcode width; decode compares the low 7 bits, and upper bits must be zero or the opcode is illegal
- CNT_W, 32, retired-instruction counter width
- TIMEOUT, 16, maximum cycles spent waiting for a ready in FETCH or MEMORY; must be ≥1
- clk in 1: single clock, rising edge
- rst in 1: asynchronous, active-low reset
- run in 1: start/continue; sampled only in IDLE and at instruction boundaries
- ALUSEL in OPC_W: opcode of the fetched instruction; valid in DECODE
- br_taken in 1: branch condition from ALU; valid in EXECUTE
- imem_ready in 1: instruction memory has returned data
- dmem_ready in 1: data memory has completed the access
- PC_en, ID_en, EX_en, MEM_en, WB_en out 1 each: stage enables; exactly one is high in each active state
- Jump_en out 1: redirect PC
- imm_en out 1: B-operand is immediate
- EXPC_en out 1: A-operand is PC
- L_or_S out 1: 1 = store, 0 = load
- WB_Ctrl out 2: 00 none, 01 ALU, 10 memory, 11 PC+4
- halted out 1: FSM in HALT
- err out 1: halt cause was illegal opcode or timeout
- retired_cnt out CNT_W: instructions completed

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- Reset drives all outputs to 0, retired_cnt to 0, and the state to IDLE.
- IDLE → FETCH when run = 1.
- FETCH (PC_en = 1) holds until imem_ready, then → DECODE.
- DECODE (ID_en = 1) latches ALUSEL into an internal opcode register and registers the decode controls, which stay stable until the next DECODE:
  - Illegal opcode → HALT with err = 1.
  - SYSTEM (1110011) → HALT with err = 0.
  - Otherwise → EXECUTE.
- EXECUTE (EX_en = 1):
  - LOAD (0000011) or STORE (0100011) → MEMORY.
  - BRANCH (1100011) → instruction end.
  - All others → WRITEBACK.
- MEMORY (MEM_en = 1) holds until dmem_ready:
  - LOAD → WRITEBACK.
  - STORE → instruction end.
- WRITEBACK (WB_en = 1) → instruction end.
- Instruction end: retired_cnt increments by 1 (wraps modulo 2^CNT_W). Next state is FETCH if run = 1, else IDLE.
- Decode table:
  - OP (0110011): imm 0, EXPC 0, WB 01.
  - OP-IMM (0010011): imm 1, WB 01.
  - LUI (0110111): imm 1, WB 01.
  - AUIPC (0010111): imm 1, EXPC 1, WB 01.
  - LOAD: imm 1, L_or_S 0, WB 10.
  - STORE: imm 1, L_or_S 1, WB 00.
  - BRANCH: imm 1, EXPC 1, WB 00.
  - JAL (1101111): imm 1, EXPC 1, WB 11.
  - JALR (1100111): imm 1, EXPC 0, WB 11.
  - Unlisted controls are 0.
- Jump_en is high only in EXECUTE, for JAL or JALR, or for BRANCH with br_taken = 1.
- Watchdog:
  - Counts cycles in FETCH and in MEMORY; clears on entry to either state.
  - If TIMEOUT cycles elapse with ready still 0 → HALT, err = 1.
  - A ready arriving on the TIMEOUT-th cycle wins; no halt occurs.
- HALT is terminal until rst:
  - Stage enables and Jump_en are 0; halted = 1.
  - retired_cnt is frozen; the halting instruction is not counted.
- run deasserting mid-instruction has no effect until instruction end.

## Timing
- Minimum cycles per instruction with zero-wait memories:
  - BRANCH 3 (F, D, E).
  - STORE 4.
  - ALU ops, LUI, AUIPC, JAL, JALR 4.
  - LOAD 5.
- Each wait cycle adds 1 cycle.
- Stage enables and halted are Moore outputs decoded from the state register; they are glitch-free and registered-state derived.
- Decode controls update on the clock edge that leaves DECODE, so they are valid from the first EXECUTE cycle.
- retired_cnt updates on the edge that leaves the final stage.
- Asynchronous reset asserted mid-instruction aborts immediately; nothing is counted.

## Structure
- ctrl_pkg holds:
  - State enum.
  - RV32I opcode constants.
  - WB_Ctrl encodings (WB_NONE, WB_ALU, WB_MEM, WB_PC4).
- Sub-module wait_timer:
  - Loadable down-counter with parameter TIMEOUT.
  - Inputs: clear, count_en, ready.
  - Output: expired.
  - Instantiated once and shared by FETCH and MEMORY.

## Test plan
- Reset with run = 1, OP opcode, both readies tied to 1 → F, D, E, W in 4 cycles; retired_cnt = 1; WB_Ctrl = 01; imm_en = 0.
- LOAD with dmem_ready delayed 3 cycles → MEM_en high for 4 cycles, then WB; 8 cycles total; WB_Ctrl = 10; L_or_S = 0.
- BRANCH with br_taken = 1, then BRANCH with br_taken = 0 → Jump_en high in EXECUTE only in the first case; no WB_en in either; 3 cycles each.
- imem_ready held 0 → HALT after exactly TIMEOUT FETCH cycles; err = 1; halted = 1; enables 0; retired_cnt unchanged. A second run with ready on the TIMEOUT-th cycle → no halt.
- Opcode 0000101, then 1110011 after a reset → HALT with err = 1 in the first case and err = 0 in the second.
- Drop run during the EXECUTE of a STORE → the STORE completes and is counted, then IDLE. Assert rst low mid-MEMORY → all outputs 0 asynchronously; after release the FSM is in IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types and constants for the multi-cycle control FSM:
//                state enumeration, RV32I major opcodes, write-back select
//                encodings and the opcode-to-control decode function.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Write-back source select
    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_PC4  = 2'b11;

    typedef struct packed {
        logic       legal;
        logic       imm;
        logic       expc;
        logic       l_or_s;
        logic [1:0] wb;
    } dec_t;

    // Maps a 7-bit major opcode to its datapath controls. SYSTEM is legal
    // but drives no controls; anything unlisted is flagged illegal.
    function automatic dec_t decode_opc(input logic [6:0] opc);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (opc)
            OPC_OP:     d.wb = WB_ALU;
            OPC_OPIMM,
            OPC_LUI:    begin d.imm = 1'b1; d.wb = WB_ALU; end
            OPC_AUIPC:  begin d.imm = 1'b1; d.expc = 1'b1; d.wb = WB_ALU; end
            OPC_LOAD:   begin d.imm = 1'b1; d.wb = WB_MEM; end
            OPC_STORE:  begin d.imm = 1'b1; d.l_or_s = 1'b1; d.wb = WB_NONE; end
            OPC_BRANCH: begin d.imm = 1'b1; d.expc = 1'b1; d.wb = WB_NONE; end
            OPC_JAL:    begin d.imm = 1'b1; d.expc = 1'b1; d.wb = WB_PC4; end
            OPC_JALR:   begin d.imm = 1'b1; d.wb = WB_PC4; end
            OPC_SYSTEM: d.wb = WB_NONE;
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wait_timer
//  Description : Ready-wait watchdog. A down-counter reloaded by clear and
//                decremented on every counted cycle without ready. expired
//                flags the TIMEOUT-th consecutive waiting cycle; a ready in
//                that same cycle suppresses it.
//  Revision    : 1.0 - initial release
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous active-low reset
//                clear    - reload the counter (state entry)
//                count_en - currently waiting in a watched state
//                ready    - handshake of the watched memory
//                expired  - TIMEOUT cycles elapsed with ready low
// ============================================================================
module wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] C_LOAD = CW'(TIMEOUT - 1);

    // Holds the number of waiting cycles still allowed after the current one.
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= C_LOAD;
        end else if (clear) begin
            r_cnt <= C_LOAD;
        end else if (count_en && !ready && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign expired = count_en & ~ready & (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_fsm
//  Description : Multi-cycle CPU control unit. Sequences FETCH / DECODE /
//                EXECUTE / MEMORY / WRITEBACK with per-opcode stage skipping,
//                memory ready handshakes and a wait-timeout watchdog, decodes
//                the RV32I major opcode into datapath controls and counts
//                retired instructions.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst           - clock / asynchronous active-low reset
//                run                - start/continue (IDLE and boundaries)
//                ALUSEL             - opcode of fetched instruction (DECODE)
//                br_taken           - branch condition (EXECUTE)
//                imem_ready         - instruction memory data returned
//                dmem_ready         - data memory access completed
//                PC_en..WB_en       - one-hot stage enables
//                Jump_en            - PC redirect
//                imm_en, EXPC_en    - operand selects
//                L_or_S             - 1 store / 0 load
//                WB_Ctrl            - write-back source
//                halted, err        - HALT state / halt due to fault
//                retired_cnt        - completed-instruction counter
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int OPC_W   = 7,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPC_W-1:0] ALUSEL,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             PC_en,
    output logic             ID_en,
    output logic             EX_en,
    output logic             MEM_en,
    output logic             WB_en,
    output logic             Jump_en,
    output logic             imm_en,
    output logic             EXPC_en,
    output logic             L_or_S,
    output logic [1:0]       WB_Ctrl,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired_cnt
);

    import ctrl_pkg::*;

    state_t           r_state;
    state_t           w_next;
    logic [6:0]       r_opcode;
    logic             r_imm;
    logic             r_expc;
    logic             r_l_or_s;
    logic [1:0]       r_wb;
    logic             r_err;
    logic [CNT_W-1:0] r_retired;

    logic [6:0]       w_opc_lo;
    logic             w_opc_hi_zero;
    dec_t             w_dec;
    logic             w_legal;
    logic             w_retire;
    logic             w_halt_err;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_is_branch;
    logic             w_is_jump;
    logic             w_wait_en;
    logic             w_wait_ready;
    logic             w_timer_clear;
    logic             w_expired;

    // ------------------------------------------------------------------
    // Opcode decode: only the low 7 bits select an instruction; any set
    // bit above them makes the opcode illegal.
    // ------------------------------------------------------------------
    assign w_opc_lo      = ALUSEL[6:0];
    assign w_opc_hi_zero = ((ALUSEL >> 7) == '0);
    assign w_dec         = decode_opc(w_opc_lo);
    assign w_legal       = w_dec.legal & w_opc_hi_zero;

    // Instruction class of the latched opcode, used after DECODE.
    assign w_is_load   = (r_opcode == OPC_LOAD);
    assign w_is_store  = (r_opcode == OPC_STORE);
    assign w_is_branch = (r_opcode == OPC_BRANCH);
    assign w_is_jump   = (r_opcode == OPC_JAL) | (r_opcode == OPC_JALR);

    // ------------------------------------------------------------------
    // Watchdog shared by FETCH and MEMORY. Any state change reloads it,
    // so it always starts fresh on entry to either watched state.
    // ------------------------------------------------------------------
    assign w_wait_en     = (r_state == S_FETCH) | (r_state == S_MEMORY);
    assign w_wait_ready  = (r_state == S_FETCH) ? imem_ready : dmem_ready;
    assign w_timer_clear = (w_next != r_state);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_timer_clear),
        .count_en (w_wait_en),
        .ready    (w_wait_ready),
        .expired  (w_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore stage outputs. Jump_en is the only output that
    // also looks at an input (br_taken), and only in EXECUTE.
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_halt_err = 1'b0;
        PC_en      = 1'b0;
        ID_en      = 1'b0;
        EX_en      = 1'b0;
        MEM_en     = 1'b0;
        WB_en      = 1'b0;
        Jump_en    = 1'b0;
        halted     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                PC_en = 1'b1;
                if (imem_ready) begin
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next     = S_HALT;
                    w_halt_err = 1'b1;
                end
            end
            S_DECODE: begin
                ID_en = 1'b1;
                if (!w_legal) begin
                    w_next     = S_HALT;
                    w_halt_err = 1'b1;
                end else if (w_opc_lo == OPC_SYSTEM) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                EX_en   = 1'b1;
                Jump_en = w_is_jump | (w_is_branch & br_taken);
                if (w_is_load || w_is_store) begin
                    w_next = S_MEMORY;
                end else if (w_is_branch) begin
                    w_retire = 1'b1;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                MEM_en = 1'b1;
                if (dmem_ready) begin
                    if (w_is_store) begin
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end else if (w_expired) begin
                    w_next     = S_HALT;
                    w_halt_err = 1'b1;
                end
            end
            S_WRITEBACK: begin
                WB_en    = 1'b1;
                w_retire = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Instruction boundary: run decides whether to continue.
        if (w_retire) begin
            w_next = run ? S_FETCH : S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Decode controls: captured on the edge leaving DECODE and held until
    // the next DECODE. An illegal opcode clears them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opcode <= '0;
            r_imm    <= 1'b0;
            r_expc   <= 1'b0;
            r_l_or_s <= 1'b0;
            r_wb     <= WB_NONE;
        end else if (r_state == S_DECODE) begin
            r_opcode <= w_opc_lo;
            r_imm    <= w_legal & w_dec.imm;
            r_expc   <= w_legal & w_dec.expc;
            r_l_or_s <= w_legal & w_dec.l_or_s;
            r_wb     <= w_legal ? w_dec.wb : WB_NONE;
        end
    end

    // ------------------------------------------------------------------
    // Halt cause and retired-instruction counter. HALT never retires, so
    // the counter freezes there on its own.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_halt_err) begin
                r_err <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign imm_en      = r_imm;
    assign EXPC_en     = r_expc;
    assign L_or_S      = r_l_or_s;
    assign WB_Ctrl     = r_wb;
    assign err         = r_err;
    assign retired_cnt = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl_fsm
//  Description : Self-checking bench for multicycle_ctrl_fsm. A constant
//                table of zero-wait instructions, hand-written corner
//                sequences, and random instruction streams compared cycle by
//                cycle against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam int OPC_W = 8;
    localparam int CNT_W = 32;
    localparam int TO    = 6;

    localparam int ST_I = 0, ST_F = 1, ST_D = 2, ST_E = 3, ST_M = 4, ST_W = 5, ST_H = 6;

    logic             clk = 1'b0;
    logic             rst, run, br_taken, imem_ready, dmem_ready;
    logic [OPC_W-1:0] ALUSEL;
    logic             PC_en, ID_en, EX_en, MEM_en, WB_en, Jump_en;
    logic             imm_en, EXPC_en, L_or_S, halted, err;
    logic [1:0]       WB_Ctrl;
    logic [CNT_W-1:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .OPC_W   (OPC_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .ALUSEL      (ALUSEL),
        .br_taken    (br_taken),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .PC_en       (PC_en),
        .ID_en       (ID_en),
        .EX_en       (EX_en),
        .MEM_en      (MEM_en),
        .WB_en       (WB_en),
        .Jump_en     (Jump_en),
        .imm_en      (imm_en),
        .EXPC_en     (EXPC_en),
        .L_or_S      (L_or_S),
        .WB_Ctrl     (WB_Ctrl),
        .halted      (halted),
        .err         (err),
        .retired_cnt (retired_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input logic [7:0] op);
        return op inside {8'h33, 8'h13, 8'h37, 8'h17, 8'h03, 8'h23, 8'h63, 8'h6F, 8'h67, 8'h73};
    endfunction

    // {imm, expc, l_or_s, wb[1:0]} straight from the decode table
    function automatic logic [4:0] ref_ctrl(input logic [7:0] op);
        case (op)
            8'h33:   return {1'b0, 1'b0, 1'b0, 2'b01};
            8'h13:   return {1'b1, 1'b0, 1'b0, 2'b01};
            8'h37:   return {1'b1, 1'b0, 1'b0, 2'b01};
            8'h17:   return {1'b1, 1'b1, 1'b0, 2'b01};
            8'h03:   return {1'b1, 1'b0, 1'b0, 2'b10};
            8'h23:   return {1'b1, 1'b0, 1'b1, 2'b00};
            8'h63:   return {1'b1, 1'b1, 1'b0, 2'b00};
            8'h6F:   return {1'b1, 1'b1, 1'b0, 2'b11};
            8'h67:   return {1'b1, 1'b0, 1'b0, 2'b11};
            default: return 5'b0;
        endcase
    endfunction

    function automatic logic [4:0] en_of(input int stg);
        case (stg)
            ST_F:    return 5'b10000;
            ST_D:    return 5'b01000;
            ST_E:    return 5'b00100;
            ST_M:    return 5'b00010;
            ST_W:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    typedef struct {
        int          stg;
        logic        imr, dmr, btk, rn;
        logic [7:0]  opc;
        logic        jmp, er, cc;
        logic [4:0]  ctrl;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] m_cnt;
    bit          m_idle, m_halt;
    int          mid_run;

    function automatic cyc_t mk(input int stg);
        cyc_t c;
        c.stg  = stg;
        c.imr  = 1'($urandom);
        c.dmr  = 1'($urandom);
        c.btk  = 1'($urandom);
        c.opc  = 8'($urandom);
        c.rn   = (mid_run < 0) ? 1'($urandom) : mid_run[0];
        c.jmp  = 1'b0;
        c.er   = 1'b0;
        c.cc   = 1'b0;
        c.ctrl = 5'b0;
        c.cnt  = m_cnt;
        return c;
    endfunction

    task automatic halt_seq(input logic e);
        for (int i = 0; i < 3; i++) begin
            cyc_t c;
            c    = mk(ST_H);
            c.er = e;
            q.push_back(c);
        end
        m_halt = 1'b1;
    endtask

    task automatic retire(input logic rn_end);
        m_cnt  = m_cnt + 32'd1;
        m_idle = !rn_end;
    endtask

    // Expected cycle trace of one instruction. wi/wd = waiting cycles before
    // the memory ready arrives (>= TO means it never arrives in time).
    task automatic build(input logic [7:0] opc, input int wi, input int wd,
                         input logic bt, input logic rn_end, input int idle_n);
        cyc_t       c;
        bit         got;
        logic [4:0] ctl;
        bit         is_ld, is_st, is_br;
        q.delete();
        ctl   = ref_ctrl(opc);
        is_ld = (opc == 8'h03);
        is_st = (opc == 8'h23);
        is_br = (opc == 8'h63);
        if (m_idle) begin
            for (int i = 0; i < idle_n; i++) begin
                c = mk(ST_I); c.rn = 1'b0; q.push_back(c);
            end
            c = mk(ST_I); c.rn = 1'b1; q.push_back(c);
        end
        got = 0;
        for (int k = 0; k < TO && !got; k++) begin
            c = mk(ST_F); c.imr = (k == wi); q.push_back(c); got = (k == wi);
        end
        if (!got) begin halt_seq(1'b1); return; end
        c = mk(ST_D); c.opc = opc; q.push_back(c);
        if (!ref_legal(opc)) begin halt_seq(1'b1); return; end
        if (opc == 8'h73) begin halt_seq(1'b0); return; end
        c      = mk(ST_E);
        c.btk  = bt;
        c.jmp  = (opc == 8'h6F) || (opc == 8'h67) || (is_br && bt);
        c.cc   = 1'b1;
        c.ctrl = ctl;
        if (is_br) c.rn = rn_end;
        q.push_back(c);
        if (is_br) begin retire(rn_end); return; end
        if (is_ld || is_st) begin
            got = 0;
            for (int k = 0; k < TO && !got; k++) begin
                c = mk(ST_M); c.dmr = (k == wd); c.cc = 1'b1; c.ctrl = ctl;
                got = (k == wd);
                if (got && is_st) c.rn = rn_end;
                q.push_back(c);
            end
            if (!got) begin halt_seq(1'b1); return; end
            if (is_st) begin retire(rn_end); return; end
        end
        c = mk(ST_W); c.cc = 1'b1; c.ctrl = ctl; c.rn = rn_end; q.push_back(c);
        retire(rn_end);
    endtask

    task automatic play(input int cut);
        for (int i = 0; i < q.size(); i++) begin
            cyc_t c;
            if (cut >= 0 && i >= cut) break;
            c = q[i];
            @(negedge clk);
            imem_ready = c.imr;
            dmem_ready = c.dmr;
            br_taken   = c.btk;
            ALUSEL     = c.opc;
            run        = c.rn;
            #1;
            chk("stage_en", {PC_en, ID_en, EX_en, MEM_en, WB_en}, en_of(c.stg));
            chk("halted", halted, (c.stg == ST_H));
            chk("jump_en", Jump_en, c.jmp);
            chk("err", err, c.er);
            chk("retired_cnt", retired_cnt, c.cnt);
            if (c.cc) chk("decode_ctrl", {imm_en, EXPC_en, L_or_S, WB_Ctrl}, c.ctrl);
        end
    endtask

    task automatic do_reset(input bit chk_now);
        rst = 1'b0;
        run = 1'b0;
        #1;
        if (chk_now)
            chk("async_reset_outs", {PC_en, ID_en, EX_en, MEM_en, WB_en, Jump_en, imm_en,
                                     EXPC_en, L_or_S, WB_Ctrl, halted, err, retired_cnt}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        m_cnt  = 32'd0;
        m_idle = 1'b1;
        m_halt = 1'b0;
    endtask

    // ---------------- constant vector table ----------------
    typedef struct {
        logic [7:0] opc;
        logic       bt;
        int         cyc;
        logic [4:0] ctrl;
        logic       jmp;
        logic       wbs;
    } vec_t;

    vec_t       tv[10];
    logic [7:0] ops[10];

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; run = 1'b0; ALUSEL = '0; br_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        m_cnt = 32'd0; m_idle = 1'b1; m_halt = 1'b0; mid_run = -1;

        tv[0] = '{opc: 8'h33, bt: 1'b0, cyc: 4, ctrl: 5'b00001, jmp: 1'b0, wbs: 1'b1};
        tv[1] = '{opc: 8'h13, bt: 1'b0, cyc: 4, ctrl: 5'b10001, jmp: 1'b0, wbs: 1'b1};
        tv[2] = '{opc: 8'h37, bt: 1'b0, cyc: 4, ctrl: 5'b10001, jmp: 1'b0, wbs: 1'b1};
        tv[3] = '{opc: 8'h17, bt: 1'b0, cyc: 4, ctrl: 5'b11001, jmp: 1'b0, wbs: 1'b1};
        tv[4] = '{opc: 8'h03, bt: 1'b0, cyc: 5, ctrl: 5'b10010, jmp: 1'b0, wbs: 1'b1};
        tv[5] = '{opc: 8'h23, bt: 1'b0, cyc: 4, ctrl: 5'b10100, jmp: 1'b0, wbs: 1'b0};
        tv[6] = '{opc: 8'h63, bt: 1'b1, cyc: 3, ctrl: 5'b11000, jmp: 1'b1, wbs: 1'b0};
        tv[7] = '{opc: 8'h63, bt: 1'b0, cyc: 3, ctrl: 5'b11000, jmp: 1'b0, wbs: 1'b0};
        tv[8] = '{opc: 8'h6F, bt: 1'b0, cyc: 4, ctrl: 5'b11011, jmp: 1'b1, wbs: 1'b1};
        tv[9] = '{opc: 8'h67, bt: 1'b0, cyc: 4, ctrl: 5'b10011, jmp: 1'b1, wbs: 1'b1};
        ops   = '{8'h33, 8'h13, 8'h37, 8'h17, 8'h03, 8'h23, 8'h63, 8'h6F, 8'h67, 8'h73};

        do_reset(1'b1);

        // Zero-wait memories, back-to-back instructions.
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int          w, n;
            logic [31:0] c0;
            logic        js, ws;
            logic [4:0]  ctl;
            ALUSEL   = tv[i].opc;
            br_taken = tv[i].bt;
            w = 0;
            while (!PC_en && w < 20) begin @(negedge clk); #1; w++; end
            chk("tbl_fetch_start", PC_en, 1'b1);
            c0 = retired_cnt; n = 0; js = 1'b0; ws = 1'b0; ctl = 5'b0;
            while (retired_cnt == c0 && n < 20) begin
                @(negedge clk); #1; n++;
                if (EX_en) begin js = js | Jump_en; ctl = {imm_en, EXPC_en, L_or_S, WB_Ctrl}; end
                if (WB_en) ws = 1'b1;
            end
            chk("tbl_cycles", n, tv[i].cyc);
            chk("tbl_ctrl", ctl, tv[i].ctrl);
            chk("tbl_jump", js, tv[i].jmp);
            chk("tbl_wb_seen", ws, tv[i].wbs);
            chk("tbl_retired", retired_cnt, i + 1);
        end

        // Hand-written corner sequences.
        do_reset(1'b0);
        build(8'h33, 0, 0, 1'b0, 1'b1, 0);      play(-1);
        build(8'h03, 0, 3, 1'b0, 1'b1, 0);      play(-1);  // 4 MEMORY cycles
        build(8'h63, 0, 0, 1'b1, 1'b1, 0);      play(-1);
        build(8'h63, 0, 0, 1'b0, 1'b1, 0);      play(-1);
        mid_run = 0;
        build(8'h23, 1, 1, 1'b0, 1'b0, 0);      play(-1);  // run low from EXECUTE on
        mid_run = -1;
        build(8'h33, 2, 0, 1'b0, 1'b1, 2);      play(-1);
        build(8'h33, TO, 0, 1'b0, 1'b1, 0);     play(-1);  // fetch timeout
        do_reset(1'b0);
        build(8'h03, TO-1, TO-1, 1'b0, 1'b1, 0); play(-1); // ready on last allowed cycle
        build(8'h23, 0, TO, 1'b0, 1'b1, 0);     play(-1);  // memory timeout
        do_reset(1'b0);
        build(8'h05, 0, 0, 1'b0, 1'b1, 0);      play(-1);
        do_reset(1'b0);
        build(8'h73, 0, 0, 1'b0, 1'b1, 0);      play(-1);
        do_reset(1'b0);
        build(8'h83, 0, 0, 1'b0, 1'b1, 0);      play(-1);  // upper opcode bit set
        do_reset(1'b0);
        build(8'h03, 0, TO+5, 1'b0, 1'b1, 0);   play(6);   // stop inside MEMORY
        do_reset(1'b1);
        build(8'h33, 0, 0, 1'b0, 1'b1, 1);      play(-1);

        // Random instruction streams.
        for (int t = 0; t < 250; t++) begin
            logic [7:0] op;
            int         wi, wd;
            op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ops[$urandom_range(0, 9)];
            wi = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO-1);
            wd = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO-1);
            build(op, wi, wd, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
            play(-1);
            if (m_halt) do_reset(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
